// File: rtl/gnrl_dfflr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gnrl_dfflr_fifo : valid/ready FIFO of load-enable, async-reset registers  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module gnrl_dfflr_fifo #(
    parameter int DW        = 32,
    parameter int DP        = 4,
    parameter int CUT_READY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    i_vld,
    output logic                    i_rdy,
    input  logic [DW-1:0]           i_dat,
    output logic                    o_vld,
    input  logic                    o_rdy,
    output logic [DW-1:0]           o_dat,
    output logic [$clog2(DP+1)-1:0] count
);

    localparam int CW = $clog2(DP + 1);
    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [PW-1:0] c_last_ptr = PW'(DP - 1);
    localparam logic [CW-1:0] c_full_cnt = CW'(DP);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_mem [DP];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_load;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    // Pass mode lets a full FIFO accept when the head is leaving this cycle.
    generate
        if (CUT_READY != 0) begin : g_ready_cut
            assign i_rdy = !w_full;
        end else begin : g_ready_pass
            assign i_rdy = !w_full || o_rdy;
        end
    endgenerate

    assign w_push = i_vld && i_rdy;
    assign w_pop  = !w_empty && o_rdy;
    assign w_load = w_push && !flush;

    // Explicit wrap so non-power-of-two depths stay within 0..DP-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DP; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DP; i++) begin
                if (w_load && (r_wptr == PW'(i))) begin
                    r_mem[i] <= i_dat;
                end
            end
        end
    end

    // Head read through a compare mux so odd depths never index past the array.
    always_comb begin
        o_dat = '0;
        for (int i = 0; i < DP; i++) begin
            if (r_rptr == PW'(i)) begin
                o_dat = r_mem[i];
            end
        end
    end

    assign o_vld = !w_empty;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gnrl_dfflr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gnrl_dfflr_fifo : three FIFO configurations against a queue model      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_gnrl_dfflr_fifo;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   flush;
    logic [N-1:0]   ivld;
    logic [N-1:0]   irdy;
    logic [N-1:0]   ovld;
    logic [N-1:0]   ordy;
    logic [31:0]    idat [N];
    logic [31:0]    odat [N];
    logic [2:0]     cnt  [N];
    logic [1:0]     cnt2_raw;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mdl [N][8];
    int          msz [N];

    always #5 clk = ~clk;

    // Instance 0: DP=4 cut-ready, 1: DP=4 pass-ready, 2: DP=3 cut-ready.
    gnrl_dfflr_fifo #(.DW(32), .DP(4), .CUT_READY(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .i_vld(ivld[0]), .i_rdy(irdy[0]), .i_dat(idat[0]),
        .o_vld(ovld[0]), .o_rdy(ordy[0]), .o_dat(odat[0]), .count(cnt[0])
    );
    gnrl_dfflr_fifo #(.DW(32), .DP(4), .CUT_READY(0)) u_c0 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .i_vld(ivld[1]), .i_rdy(irdy[1]), .i_dat(idat[1]),
        .o_vld(ovld[1]), .o_rdy(ordy[1]), .o_dat(odat[1]), .count(cnt[1])
    );
    gnrl_dfflr_fifo #(.DW(32), .DP(3), .CUT_READY(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush[2]),
        .i_vld(ivld[2]), .i_rdy(irdy[2]), .i_dat(idat[2]),
        .o_vld(ovld[2]), .o_rdy(ordy[2]), .o_dat(odat[2]), .count(cnt2_raw)
    );
    assign cnt[2] = {1'b0, cnt2_raw};

    function automatic int dp_of(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit cut_of(input int k);
        return (k != 1);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input int k, input bit v, input logic [31:0] d, input bit r, input bit f);
        ivld[k]  = v;
        idat[k]  = d;
        ordy[k]  = r;
        flush[k] = f;
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) drive(k, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: each FIFO is an ordered list; outputs checked every negedge.
    initial begin : compare
        bit erdy, epush, epop;
        for (int k = 0; k < N; k++) msz[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!rst_n) begin
                    chk("rst_o_vld", k, 32'(ovld[k]), 32'h0);
                    chk("rst_count", k, 32'(cnt[k]), 32'h0);
                    chk("rst_i_rdy", k, 32'(irdy[k]), 32'h1);
                    chk("rst_o_dat", k, odat[k], 32'h0);
                    msz[k] = 0;
                end else begin
                    erdy  = (msz[k] < dp_of(k)) || (!cut_of(k) && ordy[k]);
                    epop  = (msz[k] > 0) && ordy[k];
                    epush = ivld[k] && erdy;
                    chk("o_vld", k, 32'(ovld[k]), 32'(msz[k] > 0));
                    chk("count", k, 32'(cnt[k]), 32'(msz[k]));
                    chk("i_rdy", k, 32'(irdy[k]), 32'(erdy));
                    if (msz[k] > 0) chk("o_dat", k, odat[k], mdl[k][0]);
                    if (flush[k]) begin
                        msz[k] = 0;
                    end else begin
                        if (epop) begin
                            for (int j = 0; j < 7; j++) mdl[k][j] = mdl[k][j+1];
                            msz[k]--;
                        end
                        if (epush) begin
                            mdl[k][msz[k]] = idat[k];
                            msz[k]++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int nxt;
        int got;
        rst_n = 1'b0;
        idle_all();

        // Reset held with random inputs.
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < N; k++)
                drive(k, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            tick();
        end
        @(negedge clk);
        chk("lit_rst_odat", 0, odat[0], 32'h0);
        chk("lit_rst_irdy", 0, 32'(irdy[0]), 32'h1);
        tick();
        rst_n = 1'b1;
        idle_all();
        drive(0, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        tick();
        idle_all();
        @(negedge clk);
        chk("lit_first_dat", 0, odat[0], 32'hA5A5_A5A5);
        chk("lit_first_vld", 0, 32'(ovld[0]), 32'h1);
        chk("lit_first_cnt", 0, 32'(cnt[0]), 32'h1);
        tick();
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle_all();

        // Fill and drain, cut-ready.
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1'b1, 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(0, 1'b1, 32'h5, 1'b0, 1'b0);
        @(negedge clk);
        chk("lit_full_cnt", 0, 32'(cnt[0]), 32'h4);
        chk("lit_full_irdy", 0, 32'(irdy[0]), 32'h0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("lit_drain_dat", 0, odat[0], 32'(i));
            tick();
        end
        @(negedge clk);
        chk("lit_drained_vld", 0, 32'(ovld[0]), 32'h0);
        chk("lit_drained_cnt", 0, 32'(cnt[0]), 32'h0);
        tick();
        idle_all();

        // Full pass-through, pass-ready.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1'b1, 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1, 1'b1, 32'h5, 1'b1, 1'b0);
        @(negedge clk);
        chk("lit_pass_irdy", 1, 32'(irdy[1]), 32'h1);
        chk("lit_pass_head", 1, odat[1], 32'h1);
        tick();
        drive(1, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("lit_pass_cnt", 1, 32'(cnt[1]), 32'h4);
        for (int i = 2; i <= 5; i++) begin
            if (i > 2) @(negedge clk);
            chk("lit_pass_dat", 1, odat[1], 32'(i));
            tick();
        end
        idle_all();

        // Wrap-around on DP=3 with random handshakes.
        nxt = 0;
        got = 0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            drive(2, (nxt < 10) && ($urandom_range(0, 3) != 0), 32'(nxt),
                  $urandom_range(0, 2) != 0, 1'b0);
            @(negedge clk);
            if (ovld[2] && ordy[2]) begin
                chk("wrap_order", 2, odat[2], 32'(got));
                got++;
            end
            if (ivld[2] && irdy[2]) nxt++;
            tick();
        end
        chk("wrap_done", 2, 32'(got), 32'd10);
        idle_all();

        // Flush beats simultaneous push and pop.
        drive(0, 1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, 32'h22, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, 32'h33, 1'b1, 1'b1);
        @(negedge clk);
        chk("lit_preflush_cnt", 0, 32'(cnt[0]), 32'h2);
        tick();
        idle_all();
        @(negedge clk);
        chk("lit_flush_cnt", 0, 32'(cnt[0]), 32'h0);
        chk("lit_flush_vld", 0, 32'(ovld[0]), 32'h0);
        tick();
        drive(0, 1'b1, 32'h77, 1'b0, 1'b0);
        tick();
        idle_all();
        @(negedge clk);
        chk("lit_postflush_dat", 0, odat[0], 32'h77);
        chk("lit_postflush_cnt", 0, 32'(cnt[0]), 32'h1);
        tick();
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle_all();

        // Random soak on all instances, then drain.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++)
                drive(k, 1'($urandom), $urandom, 1'($urandom),
                      $urandom_range(0, 31) == 0);
            tick();
        end
        for (int k = 0; k < N; k++) drive(k, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (6) tick();
        idle_all();

        // Asynchronous reset mid-stream.
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1'b1, 32'(i + 8'hC0), 1'b0, 1'b0);
            tick();
        end
        idle_all();
        @(negedge clk);
        chk("lit_prereset_cnt", 0, 32'(cnt[0]), 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("lit_async_vld", 0, 32'(ovld[0]), 32'h0);
        chk("lit_async_cnt", 0, 32'(cnt[0]), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(0, 1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
        tick();
        idle_all();
        @(negedge clk);
        chk("lit_fresh_dat", 0, odat[0], 32'h5A5A_0001);
        chk("lit_fresh_cnt", 0, 32'(cnt[0]), 32'h1);
        tick();
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle_all();
        @(negedge clk);
        chk("lit_fresh_empty", 0, 32'(ovld[0]), 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gnrl_dfflr_fifo.md
# gnrl_dfflr_fifo

Parametrised synchronous FIFO built from load-enable, async-reset storage registers. It generalises the single load-enable flop into DP entries of DW bits with a valid/ready handshake on both sides, an occupancy count, a synchronous flush and a selectable ready-cut mode. It sits between pipeline stages (fetch → decode, LSU → bus) wherever back-pressure must be absorbed without combinational ready paths.

## Interface
- DW, 32, data width in bits (≥1)
- DP, 4, depth in entries (≥1; need not be a power of two)
- CUT_READY, 0, 1: i_rdy depends only on internal state; 0: i_rdy also asserts when full and o_rdy=1
- CW, $clog2(DP+1), width of count (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries' valid state
- i_vld  in  1  upstream data valid
- i_rdy  out  1  FIFO can accept
- i_dat  in  DW  upstream data
- o_vld  out  1  FIFO head valid
- o_rdy  in  1  downstream accepts head
- o_dat  out  DW  head data
- count  out  CW  entries currently held (0..DP)

## Operation
- push = i_vld & i_rdy; pop = o_vld & o_rdy.
- Storage: DP × DW registers, each written only on push to the entry at wptr (load-enable); reset value all zeros.
- Pointers wptr, rptr range 0..DP-1; increment wraps from DP-1 to 0 (explicit compare, not modulo-2^n).
- count: +1 on push only, −1 on pop only, unchanged on push&pop or neither.
- empty = (count==0); full = (count==DP).
- o_vld = !empty; o_dat = storage[rptr] (registered data, no input-to-output bypass).
- i_rdy: CUT_READY=1 → !full; CUT_READY=0 → !full | o_rdy.
- Simultaneous push and pop when full (CUT_READY=0): head leaves, new data written into freed slot; count stays DP.
- Simultaneous push and pop when empty: impossible (o_vld=0), push only.
- flush: next edge sets wptr=rptr=0, count=0; storage data untouched. flush has priority over push and pop in the same cycle (both discarded). i_rdy and o_vld are not gated by flush in the flush cycle; upstream/downstream must treat that cycle's handshakes as dropped.
- DP=1: single entry; CUT_READY=0 allows back-to-back throughput of 1/cycle, CUT_READY=1 gives 1 per 2 cycles.
- No overflow/underflow possible through the handshake; i_vld while !i_rdy leaves state unchanged.

## Timing
- Reset (rst_n=0, asynchronous): wptr=0, rptr=0, count=0, all storage 0 → o_vld=0, o_dat=0, count=0, i_rdy=1.
- Reset deassertion synchronous to clk by the instantiating level; first push accepted on the first rising edge with rst_n=1.
- Latency: data pushed on edge N is visible at o_dat with o_vld=1 after edge N (1-cycle minimum).
- Throughput: 1 push and 1 pop per cycle sustained for DP≥2 in either mode.
- Combinational paths: o_rdy → i_rdy only when CUT_READY=0; no i_vld → o_vld path; no i_dat → o_dat path.
- Reset mid-operation: all contents discarded immediately, outputs return to reset values without waiting for clk.

## Test plan
- Reset: hold rst_n=0 with random inputs → o_vld=0, o_dat=0, count=0, i_rdy=1; release, push 0xA5A5A5A5 → next cycle o_vld=1, o_dat=0xA5A5A5A5, count=1.
- Fill/drain DP=4, o_rdy=0: push 0x1..0x4 → count=4, i_rdy=0 (CUT_READY=1); push 0x5 ignored; then o_rdy=1 → pops 0x1,0x2,0x3,0x4 in order, o_vld=0 after 4th, count=0.
- Full pass-through CUT_READY=0, DP=4 full with 0x1..0x4, o_rdy=1, i_vld=1 data 0x5 → i_rdy=1, pop 0x1, count stays 4, subsequent heads 0x2,0x3,0x4,0x5.
- Wrap-around DP=3: stream 10 values 0..9 with random i_vld/o_rdy → output order 0..9 exact, count never exceeds 3, pointers wrap correctly.
- Flush with push&pop same cycle, count=2 → next cycle count=0, o_vld=0; next push 0x77 appears at o_dat one cycle later, count=1.
- Async reset mid-stream with count=3 → o_vld, count drop to 0 before next clk edge; post-reset push/pop sequence behaves as fresh.
